// File: rtl/alarm_pkg.sv
// Shared constants for the alarm matcher: FSM encoding and BCD word layout.
// Snooze support is built only when ALARM_SNOOZE_EN is defined.
package alarm_pkg;

  localparam int WORD_W = 13;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RING   = 2'd1;
  localparam logic [1:0] ST_SNOOZE = 2'd2;

  localparam int HT_MSB = 12;
  localparam int HT_LSB = 11;
  localparam int HU_MSB = 10;
  localparam int HU_LSB = 7;
  localparam int MT_MSB = 6;
  localparam int MT_LSB = 4;
  localparam int MU_MSB = 3;
  localparam int MU_LSB = 0;

  localparam logic [1:0] DISABLED_HT = 2'b11;
  localparam logic [WORD_W-1:0] DISABLED_WORD = {DISABLED_HT, 11'd0};

  function automatic logic word_enabled(input logic [WORD_W-1:0] w);
    return w[HT_MSB:HT_LSB] != DISABLED_HT;
  endfunction

endpackage

// File: rtl/alarm_day_mux.sv
// Selects the stored alarm word for the current day.
// Day 7 is not a real day and yields a disabled word.
module alarm_day_mux
  import alarm_pkg::*;
(
  input  logic [WORD_W-1:0] Q_r0,
  input  logic [WORD_W-1:0] Q_r1,
  input  logic [WORD_W-1:0] Q_r2,
  input  logic [WORD_W-1:0] Q_r3,
  input  logic [WORD_W-1:0] Q_r4,
  input  logic [WORD_W-1:0] Q_r5,
  input  logic [WORD_W-1:0] Q_r6,
  input  logic [2:0]        day,
  output logic [WORD_W-1:0] sel_word
);

  always_comb begin
    sel_word = DISABLED_WORD;
    unique case (day)
      3'd0: sel_word = Q_r0;
      3'd1: sel_word = Q_r1;
      3'd2: sel_word = Q_r2;
      3'd3: sel_word = Q_r3;
      3'd4: sel_word = Q_r4;
      3'd5: sel_word = Q_r5;
      3'd6: sel_word = Q_r6;
      3'd7: sel_word = DISABLED_WORD;
    endcase
  end

endmodule

// File: rtl/alarm_match_module.sv
// Alarm matcher with ring timeout and optional snooze.
// Snooze logic is present only when ALARM_SNOOZE_EN is defined.
module alarm_match_module
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MIN   = 5,
  parameter int RING_TIMEOUT = 10,
  parameter int MAX_SNOOZE   = 3
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic [WORD_W-1:0] Q_r0,
  input  logic [WORD_W-1:0] Q_r1,
  input  logic [WORD_W-1:0] Q_r2,
  input  logic [WORD_W-1:0] Q_r3,
  input  logic [WORD_W-1:0] Q_r4,
  input  logic [WORD_W-1:0] Q_r5,
  input  logic [WORD_W-1:0] Q_r6,
  input  logic [2:0]        day,
  input  logic [WORD_W-1:0] now,
  input  logic              min_tick,
  input  logic              ack,
  input  logic              snooze,
  output logic              ring,
  output logic [1:0]        state,
  output logic [1:0]        snooze_cnt
);

  localparam logic [3:0] RING_TO = 4'(RING_TIMEOUT);

  logic [WORD_W-1:0] sel_word;
  logic              match;
  logic [1:0]        state_d, state_q;
  logic [3:0]        cnt_d, cnt_q;
  logic              ring_d, ring_q;

  alarm_day_mux u_mux (
    .Q_r0     (Q_r0),
    .Q_r1     (Q_r1),
    .Q_r2     (Q_r2),
    .Q_r3     (Q_r3),
    .Q_r4     (Q_r4),
    .Q_r5     (Q_r5),
    .Q_r6     (Q_r6),
    .day      (day),
    .sel_word (sel_word)
  );

  assign match = min_tick & word_enabled(sel_word)
               & (sel_word == now);

`ifdef ALARM_SNOOZE_EN
  localparam logic [3:0] SNZ_LOAD = 4'(SNOOZE_MIN);
  localparam logic [1:0] SNZ_MAX  = 2'(MAX_SNOOZE);

  logic [1:0] snz_d, snz_q;
  logic       snz_go;

  assign snz_go = snooze & (snz_q < SNZ_MAX);
`else
  logic unused_snooze;
  assign unused_snooze = snooze;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef ALARM_SNOOZE_EN
    snz_d   = snz_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (match) begin
          state_d = ST_RING;
          cnt_d   = 4'd0;
`ifdef ALARM_SNOOZE_EN
          snz_d   = 2'd0;
`endif
        end
      end
      ST_RING: begin
        if (ack) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
`ifdef ALARM_SNOOZE_EN
        end else if (snz_go) begin
          state_d = ST_SNOOZE;
          snz_d   = snz_q + 2'd1;
          cnt_d   = SNZ_LOAD;
`endif
        end else if (min_tick) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == RING_TO) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
          end
        end
      end
      ST_SNOOZE: begin
        if (ack) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (min_tick) begin
          // <=1 also covers a zero count from a corrupted load
          if (cnt_q <= 4'd1) begin
            state_d = ST_RING;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    ring_d = (state_d == ST_RING);
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ring_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ring_q  <= ring_d;
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) snz_q <= 2'd0;
    else     snz_q <= snz_d;
  end
  assign snooze_cnt = snz_q;
`else
  assign snooze_cnt = 2'd0;
`endif

  assign ring  = ring_q;
  assign state = state_q;

endmodule

// File: tb/tb_alarm_match_module.sv
// Scoreboard bench for alarm_match_module; follows ALARM_SNOOZE_EN
// to choose between the snooze and no-snooze scenarios.
module tb_alarm_match_module;

  typedef struct {
    logic       ring;
    logic [1:0] st;
    logic [1:0] sc;
    string      name;
  } exp_t;

  logic        Clk, Clr;
  logic [12:0] Q_r0, Q_r1, Q_r2, Q_r3, Q_r4, Q_r5, Q_r6;
  logic [2:0]  day;
  logic [12:0] now;
  logic        min_tick, ack, snooze;
  logic        ring;
  logic [1:0]  state, snooze_cnt;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  alarm_match_module dut (
    .Clk        (Clk),
    .Clr        (Clr),
    .Q_r0       (Q_r0),
    .Q_r1       (Q_r1),
    .Q_r2       (Q_r2),
    .Q_r3       (Q_r3),
    .Q_r4       (Q_r4),
    .Q_r5       (Q_r5),
    .Q_r6       (Q_r6),
    .day        (day),
    .now        (now),
    .min_tick   (min_tick),
    .ack        (ack),
    .snooze     (snooze),
    .ring       (ring),
    .state      (state),
    .snooze_cnt (snooze_cnt)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [12:0] bcd(input int h, input int m);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
  endfunction

  task automatic expect_out(input logic r, input logic [1:0] st,
                            input logic [1:0] sc, input string nm);
    exp_t e;
    e.ring = r;
    e.st   = st;
    e.sc   = sc;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step(input logic mt, input logic a, input logic s);
    min_tick = mt;
    ack      = a;
    snooze   = s;
    @(posedge Clk);
    #1;
    min_tick = 1'b0;
    ack      = 1'b0;
    snooze   = 1'b0;
  endtask

  always @(negedge Clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (ring !== e.ring || state !== e.st || snooze_cnt !== e.sc) begin
        miscompares++;
        $display("FAIL %s: got ring=%b state=%0d cnt=%0d, want ring=%b state=%0d cnt=%0d",
                 e.name, ring, state, snooze_cnt, e.ring, e.st, e.sc);
      end
    end
  end

  logic [12:0] t730, t731;

  initial begin
    t730 = bcd(7, 30);
    t731 = bcd(7, 31);
    Clr = 1'b1;
    Q_r0 = bcd(6, 0);
    Q_r1 = t730;
    Q_r2 = bcd(8, 0);
    Q_r3 = bcd(9, 15);
    Q_r4 = bcd(10, 0);
    Q_r5 = bcd(11, 0);
    Q_r6 = bcd(12, 0);
    day = 3'd1;
    now = t731;
    min_tick = 0; ack = 0; snooze = 0;
    @(posedge Clk); #1;
    expect_out(0, 0, 0, "reset");
    step(0, 0, 0);
    Clr = 1'b0;
    step(1, 0, 0);
    expect_out(0, 0, 0, "idle_nomatch");

    now = t730;
    step(0, 0, 0);
    expect_out(0, 0, 0, "match_no_tick");
    step(1, 0, 0);
    expect_out(1, 1, 0, "match_ring");
    step(1, 0, 0);
    expect_out(1, 1, 0, "rematch_in_ring");
    step(0, 1, 0);
    expect_out(0, 0, 0, "ack_idle");
    step(0, 1, 1);
    expect_out(0, 0, 0, "ack_snz_in_idle");

    step(1, 0, 0);
    expect_out(1, 1, 0, "ring2");
    step(0, 1, 1);
    expect_out(0, 0, 0, "ack_beats_snooze");
    step(1, 0, 0);
    now = t731;
    step(1, 1, 0);
    expect_out(0, 0, 0, "ack_beats_tick");

    now = t730;
    step(1, 0, 0);
    now = t731;
    for (int i = 0; i < 9; i++) step(1, 0, 0);
    expect_out(1, 1, 0, "ring_after_9");
    step(1, 0, 0);
    expect_out(0, 0, 0, "timeout_10");

    Q_r3 = {2'b11, 11'h1AB};
    now  = Q_r3;
    day  = 3'd3;
    step(1, 0, 0);
    expect_out(0, 0, 0, "disabled_word");

    now = bcd(5, 45);
    {Q_r0, Q_r1, Q_r2, Q_r3, Q_r4, Q_r5, Q_r6} = {7{now}};
    day = 3'd7;
    step(1, 0, 0);
    expect_out(0, 0, 0, "day7_nomatch");
    day = 3'd6;
    step(1, 0, 0);
    expect_out(1, 1, 0, "day6_match");
    step(0, 1, 0);
    now = t731;
    Q_r1 = t730;
    day = 3'd1;

`ifdef ALARM_SNOOZE_EN
    now = t730;
    step(1, 0, 0);
    now = t731;
    for (int k = 1; k <= 3; k++) begin
      step(0, 0, 1);
      expect_out(0, 2, 2'(k), "snooze_enter");
      for (int i = 0; i < 4; i++) step(1, 0, 0);
      expect_out(0, 2, 2'(k), "snooze_4ticks");
      step(1, 0, 0);
      expect_out(1, 1, 2'(k), "snooze_expire");
    end
    step(0, 0, 1);
    expect_out(1, 1, 3, "snooze_sat");
    step(0, 1, 0);
    expect_out(0, 0, 3, "ack_hold_cnt");
    now = t730;
    step(1, 0, 0);
    expect_out(1, 1, 0, "cnt_cleared");
    step(0, 0, 1);
    step(1, 0, 0);
    expect_out(0, 2, 1, "match_in_snooze");
    Clr = 1'b1;
    expect_out(0, 0, 0, "clr_mid_snooze");
`else
    now = t730;
    step(1, 0, 0);
    now = t731;
    step(0, 0, 1);
    expect_out(1, 1, 0, "snooze_disabled");
    step(1, 0, 0);
    Clr = 1'b1;
    expect_out(0, 0, 0, "clr_mid_ring");
`endif
    @(posedge Clk); #1;
    expect_out(0, 0, 0, "clr_held");
    Clr = 1'b0;
    now = t730;
    step(1, 0, 0);
    expect_out(1, 1, 0, "match_after_clr");

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge Clk);
    #1;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL %s: never checked, want ring=%b", e.name, e.ring);
    end
    if (vectors < 12) begin
      miscompares++;
      $display("FAIL only %0d vectors checked", vectors);
    end
    if (miscompares == 0)
      $display("PASS");
    else
      $display("FAIL");
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alarm_match_module.md
ALARM_MATCH_MODULE -- requirements
Module: alarm_match_module

Interface
REQ-001 SHALL have parameter SNOOZE_MIN, default 5: minutes per snooze interval.
REQ-002 SHALL have parameter RING_TIMEOUT, default 10: minutes of unacknowledged ringing before auto-stop.
REQ-003 SHALL have parameter MAX_SNOOZE, default 3: snoozes allowed per alarm event.
REQ-004 SHALL have port Clk, input, 1: single system clock, rising edge.
REQ-005 SHALL have port Clr, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have ports Q_r0..Q_r6, input, 13 each: stored alarm words, Sunday..Saturday.
REQ-007 SHALL have port day, input, 3: current day index, 0=Sunday..6=Saturday.
REQ-008 SHALL have port now, input, 13: current time, same word format as Q_rN.
REQ-009 SHALL have port min_tick, input, 1: one-cycle pulse; now holds the new minute in that cycle.
REQ-010 SHALL have port ack, input, 1: one-cycle pulse, stop alarm.
REQ-011 SHALL have port snooze, input, 1: one-cycle pulse, request snooze.
REQ-012 SHALL have port ring, output, 1: buzzer drive.
REQ-013 SHALL have port state, output, 2: FSM state, for display.
REQ-014 SHALL have port snooze_cnt, output, 2: snoozes used in the current event.

Function
REQ-015 SHALL treat each 13-bit word as BCD HH:MM: [12:11] hour tens, [10:7] hour units, [6:4] minute tens, [3:0] minute units.
REQ-016 SHALL treat a word with [12:11]=2'b11 as disabled, never matching.
REQ-017 SHALL select Q_r[day]; day=7 SHALL select no alarm (never matches).
REQ-018 SHALL define match = min_tick & selected word enabled & selected word == now.
REQ-019 SHALL implement FSM IDLE=0, RING=1, SNOOZE=2; encoding 3 unused, SHALL recover to IDLE next cycle.
REQ-020 IDLE: match -> RING, clear snooze_cnt, clear minute counter; ring=1 from the cycle after the match cycle.
REQ-021 RING: ack -> IDLE; else snooze & snooze_cnt<MAX_SNOOZE -> SNOOZE, snooze_cnt+1, load counter=SNOOZE_MIN; else min_tick increments counter, counter reaching RING_TIMEOUT -> IDLE.
REQ-022 RING: snooze with snooze_cnt==MAX_SNOOZE SHALL be ignored, ringing continues.
REQ-023 SNOOZE: ack -> IDLE; else min_tick decrements counter, reaching 0 -> RING with counter cleared.
REQ-024 ring SHALL equal (state==RING), registered, no combinational path from inputs.
REQ-025 ack and snooze in the same cycle: ack SHALL win.
REQ-026 ack and min_tick in the same cycle: ack SHALL win.
REQ-027 match while in RING or SNOOZE SHALL be ignored.
REQ-028 ack or snooze in IDLE SHALL have no effect.
REQ-029 snooze_cnt SHALL saturate at MAX_SNOOZE and hold its value after return to IDLE until the next match.
REQ-030 The minute counter SHALL be 4 bits; SNOOZE_MIN and RING_TIMEOUT SHALL each be in 1..15.

Reset
REQ-031 Clr high SHALL immediately force state=IDLE, ring=0, snooze_cnt=0, counter=0, at any point including mid-RING or mid-SNOOZE.
REQ-032 After Clr deasserts, the first match SHALL be honoured normally.

Configuration
REQ-033 Macro ALARM_SNOOZE_EN defined: snooze behaviour as REQ-021..REQ-023.
REQ-034 ALARM_SNOOZE_EN undefined: snooze input ignored, SNOOZE state unreachable, snooze_cnt tied 0, ports unchanged.

Structure
REQ-035 Package alarm_pkg SHALL hold the state encoding, word field positions and the DISABLED hour-tens code 2'b11.
REQ-036 Sub-module alarm_day_mux SHALL perform the combinational 8:1 selection of Q_r0..Q_r6 by day, outputting the disabled word for day=7.

Verification
REQ-037 Q_r1=07:30, day=1, now=07:30 with min_tick -> ring=1 the next cycle, state=RING.
REQ-038 Ringing, snooze pulse -> state=SNOOZE, snooze_cnt=1, ring=0; after 5 min_ticks -> ring=1.
REQ-039 Three snoozes used, fourth snooze pulse -> ignored, ring stays 1; ack -> IDLE, ring=0, snooze_cnt=3.
REQ-040 Ringing, no ack, 10 min_ticks -> IDLE and ring=0 after the 10th tick; ack and snooze pulsed together while ringing -> IDLE.
REQ-041 Q_r3=2'b11 hour tens with day=3, or any word with day=7 -> no ring; Clr asserted mid-SNOOZE -> IDLE, all outputs 0 immediately.
REQ-042 Build without ALARM_SNOOZE_EN, snooze pulse while ringing -> stays RING, snooze_cnt=0.
